// File: rtl/rv32i_types_pkg.sv
// Shared types for the branch resolve unit: prediction entry layout, FSM states
// and the small arithmetic helpers used by the resolve path.
package rv32i_types_pkg;

    typedef logic [31:0] word_t;

    typedef struct packed {
        word_t pc;
        logic  taken;
        word_t target;
        logic  is_rv32c;
    } pred_entry_t;

    typedef enum logic {
        IDLE,
        REDIRECT
    } bru_state_t;

    localparam word_t WORD_MAX = '1;

    function automatic word_t fallthrough_pc(input pred_entry_t e);
        return e.pc + (e.is_rv32c ? 32'd2 : 32'd4);
    endfunction

    function automatic word_t sat_inc(input word_t v);
        return (v == WORD_MAX) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/pred_fifo.sv
// In-order queue of in-flight predictions; flush empties it and drops any
// same-cycle push.
module pred_fifo
    import rv32i_types_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter type         entry_t = pred_entry_t
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  entry_t                     wr_data_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    output entry_t                     rd_data_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    entry_t          mem_q [DEPTH];
    logic [PW-1:0]   rd_ptr_q;
    logic [PW-1:0]   wr_ptr_q;
    logic [CW-1:0]   count_q;
    logic            do_push;
    logic            do_pop;

    assign do_push   = push_i && !flush_i && (count_q != CW'(DEPTH));
    assign do_pop    = pop_i && (count_q != '0);
    assign rd_data_o = mem_q[rd_ptr_q];
    assign count_o   = count_q;

    // DEPTH is a power of two, so natural pointer overflow gives the modulo wrap
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Matches execute-stage branch outcomes against queued predictions, issuing
// fetch redirects on mispredict and training updates on every resolve.
module branch_resolve_unit
    import rv32i_types_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        pred_valid,
    input  logic [31:0] pred_pc,
    input  logic        pred_taken,
    input  logic [31:0] pred_target,
    input  logic        pred_is_rv32c,
    output logic        pred_ready,
    input  logic        res_valid,
    input  logic        res_taken,
    input  logic [31:0] res_target,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        update_valid,
    output logic [31:0] update_pc,
    output logic        update_taken,
    output logic [31:0] update_target,
    output logic [31:0] branch_count,
    output logic [31:0] mispredict_count,
    output logic        res_err
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    bru_state_t    state_q;
    logic          redirect_q;
    word_t         redirect_pc_q;
    logic          update_valid_q;
    word_t         update_pc_q;
    logic          update_taken_q;
    word_t         update_target_q;
    word_t         branch_cnt_q;
    word_t         mispred_cnt_q;
    logic          res_err_q;

    pred_entry_t   new_entry;
    pred_entry_t   head;
    logic [CW-1:0] fifo_count;
    logic          resolve;
    logic          mispredict;
    logic          push;
    word_t         correct_pc;

    assign new_entry = '{pc: pred_pc, taken: pred_taken, target: pred_target,
                         is_rv32c: pred_is_rv32c};

    assign pred_ready = (fifo_count < CW'(DEPTH)) && (state_q == IDLE);
    assign resolve    = res_valid && (fifo_count != '0) && (state_q == IDLE);
    assign mispredict = resolve && ((head.taken != res_taken) ||
                                    (res_taken && (head.target != res_target)));
    assign correct_pc = res_taken ? res_target : fallthrough_pc(head);
    assign push       = pred_valid && pred_ready;

    pred_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (pred_entry_t)
    ) u_fifo (
        .clk_i     (CLK),
        .rst_ni    (nRST),
        .push_i    (push),
        .wr_data_i (new_entry),
        .pop_i     (resolve),
        .flush_i   (mispredict),
        .rd_data_o (head),
        .count_o   (fifo_count)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q         <= IDLE;
            redirect_q      <= 1'b0;
            redirect_pc_q   <= '0;
            update_valid_q  <= 1'b0;
            update_pc_q     <= '0;
            update_taken_q  <= 1'b0;
            update_target_q <= '0;
            branch_cnt_q    <= '0;
            mispred_cnt_q   <= '0;
            res_err_q       <= 1'b0;
        end else begin
            redirect_q     <= 1'b0;
            update_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (resolve) begin
                        update_valid_q  <= 1'b1;
                        update_pc_q     <= head.pc;
                        update_taken_q  <= res_taken;
                        update_target_q <= res_target;
                        branch_cnt_q    <= sat_inc(branch_cnt_q);
                        if (mispredict) begin
                            redirect_q    <= 1'b1;
                            redirect_pc_q <= correct_pc;
                            mispred_cnt_q <= sat_inc(mispred_cnt_q);
                            state_q       <= REDIRECT;
                        end
                    end else if (res_valid) begin
                        res_err_q <= 1'b1;
                    end
                end
                REDIRECT: state_q <= IDLE;
                default:  state_q <= IDLE;
            endcase
        end
    end

    assign redirect         = redirect_q;
    assign redirect_pc      = redirect_pc_q;
    assign update_valid     = update_valid_q;
    assign update_pc        = update_pc_q;
    assign update_taken     = update_taken_q;
    assign update_target    = update_target_q;
    assign branch_count     = branch_cnt_q;
    assign mispredict_count = mispred_cnt_q;
    assign res_err          = res_err_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Randomized scoreboard bench for branch_resolve_unit with a queue-based
// reference model of the prediction/resolve rules.
module tb_branch_resolve_unit;
    import rv32i_types_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic        CLK;
    logic        nRST;
    logic        pred_valid;
    logic [31:0] pred_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        pred_is_rv32c;
    logic        pred_ready;
    logic        res_valid;
    logic        res_taken;
    logic [31:0] res_target;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        update_valid;
    logic [31:0] update_pc;
    logic        update_taken;
    logic [31:0] update_target;
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;
    logic        res_err;

    branch_resolve_unit #(.DEPTH(DEPTH)) dut (
        .CLK              (CLK),
        .nRST             (nRST),
        .pred_valid       (pred_valid),
        .pred_pc          (pred_pc),
        .pred_taken       (pred_taken),
        .pred_target      (pred_target),
        .pred_is_rv32c    (pred_is_rv32c),
        .pred_ready       (pred_ready),
        .res_valid        (res_valid),
        .res_taken        (res_taken),
        .res_target       (res_target),
        .redirect         (redirect),
        .redirect_pc      (redirect_pc),
        .update_valid     (update_valid),
        .update_pc        (update_pc),
        .update_taken     (update_taken),
        .update_target    (update_target),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count),
        .res_err          (res_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
    } upd_t;

    // Reference model state
    pred_entry_t mq[$];
    upd_t        exp_upd[$];
    logic [31:0] exp_redir[$];
    bit          m_redir_state;
    logic [31:0] m_brc;
    logic [31:0] m_mpc;
    bit          m_err;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        exp_upd.delete();
        exp_redir.delete();
        m_redir_state = 0;
        m_brc = 0;
        m_mpc = 0;
        m_err = 0;
    endtask

    task automatic drive_idle();
        pred_valid = 0; pred_pc = 0; pred_taken = 0; pred_target = 0; pred_is_rv32c = 0;
        res_valid = 0; res_taken = 0; res_target = 0;
    endtask

    // One cycle of stimulus; the model advances to the state the DUT will hold after the next edge.
    task automatic step(input bit pv, input logic [31:0] pc, input bit pt, input logic [31:0] ptg,
                        input bit c16, input bit rv, input bit rt, input logic [31:0] rtg);
        bit          ready;
        bit          enq;
        bit          mis;
        pred_entry_t h;
        upd_t        u;
        logic [31:0] good;
        @(negedge CLK);
        pred_valid = pv; pred_pc = pc; pred_taken = pt; pred_target = ptg; pred_is_rv32c = c16;
        res_valid = rv; res_taken = rt; res_target = rtg;
        ready = (mq.size() < DEPTH) && !m_redir_state;
        chk("pred_ready", {31'd0, pred_ready}, {31'd0, ready});
        enq = pv && ready;
        if (m_redir_state) begin
            m_redir_state = 0;
        end else if (rv) begin
            if (mq.size() == 0) begin
                m_err = 1;
            end else begin
                h = mq.pop_front();
                good = rt ? rtg : h.pc + (h.is_rv32c ? 32'd2 : 32'd4);
                mis = (h.taken != rt) || (rt && (h.target != rtg));
                u.pc = h.pc; u.taken = rt; u.target = rtg;
                exp_upd.push_back(u);
                if (m_brc != 32'hFFFF_FFFF) m_brc++;
                if (mis) begin
                    if (m_mpc != 32'hFFFF_FFFF) m_mpc++;
                    exp_redir.push_back(good);
                    mq.delete();
                    m_redir_state = 1;
                    enq = 0;
                end
            end
        end
        if (enq) mq.push_back('{pc: pc, taken: pt, target: ptg, is_rv32c: c16});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        nRST = 0;
        drive_idle();
        model_clear();
        #2;
        chk("rst_redirect", {31'd0, redirect}, 0);
        chk("rst_redirect_pc", redirect_pc, 0);
        chk("rst_update_valid", {31'd0, update_valid}, 0);
        chk("rst_update_pc", update_pc, 0);
        chk("rst_update_taken", {31'd0, update_taken}, 0);
        chk("rst_update_target", update_target, 0);
        chk("rst_branch_count", branch_count, 0);
        chk("rst_mispredict_count", mispredict_count, 0);
        chk("rst_res_err", {31'd0, res_err}, 0);
        chk("rst_pred_ready", {31'd0, pred_ready}, 1);
        @(negedge CLK);
        nRST = 1;
    endtask

    // Monitor: every update/redirect the DUT presents must match the next queued expectation.
    always @(posedge CLK) begin
        upd_t        u;
        logic [31:0] r;
        #1;
        if (nRST) begin
            if (update_valid) begin
                if (exp_upd.size() == 0) begin
                    chk("update_unexpected", 1, 0);
                end else begin
                    u = exp_upd.pop_front();
                    chk("update_pc", update_pc, u.pc);
                    chk("update_taken", {31'd0, update_taken}, {31'd0, u.taken});
                    chk("update_target", update_target, u.target);
                end
            end else if (exp_upd.size() != 0) begin
                chk("update_missing", 0, 1);
                void'(exp_upd.pop_front());
            end
            if (redirect) begin
                if (exp_redir.size() == 0) begin
                    chk("redirect_unexpected", 1, 0);
                end else begin
                    r = exp_redir.pop_front();
                    chk("redirect_pc", redirect_pc, r);
                end
            end else if (exp_redir.size() != 0) begin
                chk("redirect_missing", 0, 1);
                void'(exp_redir.pop_front());
            end
            chk("branch_count", branch_count, m_brc);
            chk("mispredict_count", mispredict_count, m_mpc);
            chk("res_err", {31'd0, res_err}, {31'd0, m_err});
        end
    end

    function automatic logic [31:0] rnd_tgt();
        case ($urandom_range(0, 3))
            0:       return 32'h1000;
            1:       return 32'h1004;
            2:       return 32'h2000;
            default: return 32'h3000;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        nRST = 0;
        drive_idle();
        model_clear();
        do_reset();

        // Correct taken prediction
        step(1, 32'h100, 1, 32'hF0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 1, 32'hF0);
        idle(2);

        // Not-taken compressed branch resolves taken
        step(1, 32'h200, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 1, 32'h180);
        idle(2);

        // Fill, correct resolve, then mispredict flushes the rest
        step(1, 32'h300, 0, 0, 0, 0, 0, 0);
        step(1, 32'h304, 0, 0, 0, 0, 0, 0);
        step(1, 32'h308, 0, 0, 0, 0, 0, 0);
        step(1, 32'h30C, 0, 0, 0, 0, 0, 0);
        step(1, 32'h310, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 1, 1, 32'h340);
        step(1, 32'h500, 0, 0, 0, 1, 0, 0);
        idle(2);

        // Taken prediction resolves not-taken; same-cycle enqueue dropped
        step(1, 32'h400, 1, 32'h3F0, 0, 0, 0, 0);
        step(1, 32'h600, 1, 32'h700, 0, 1, 0, 0);
        idle(1);
        step(0, 0, 0, 0, 0, 1, 0, 0);
        idle(2);

        // Empty resolve after reset, then reset with two entries queued
        do_reset();
        step(0, 0, 0, 0, 0, 1, 1, 32'h44);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 32'h800, 1, 32'h900, 0, 0, 0, 0);
        step(1, 32'h804, 0, 0, 1, 0, 0, 0);
        do_reset();
        idle(2);

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 9) < 6, $urandom & 32'hFFFF_FFFE, 1'($urandom_range(0, 1)),
                     rnd_tgt(), 1'($urandom_range(0, 1)), $urandom_range(0, 9) < 4,
                     1'($urandom_range(0, 1)), rnd_tgt());
            end
        end
        idle(3);
        @(posedge CLK);
        #2;
        chk("drain_updates", exp_upd.size(), 0);
        chk("drain_redirects", exp_redir.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 4, giving the number of in-flight prediction entries (power of two, 2..16).
REQ-002 SHALL have port CLK  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port nRST  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port pred_valid  input  1  the fetch stage enqueues a predicted branch this cycle.
REQ-005 SHALL have port pred_pc  input  32  PC of the predicted branch.
REQ-006 SHALL have ports pred_taken (input, 1) and pred_target (input, 32): the predictor's direction and its target address.
REQ-007 SHALL have port pred_is_rv32c  input  1  the branch is a 16-bit compressed instruction.
REQ-008 SHALL have port pred_ready  output  1  an enqueue is accepted this cycle.
REQ-009 SHALL have ports res_valid (input, 1), res_taken (input, 1) and res_target (input, 32): execute resolves the oldest branch with its actual outcome.
REQ-010 SHALL have ports redirect (output, 1) and redirect_pc (output, 32): a one-cycle fetch redirect and its address.
REQ-011 SHALL have ports update_valid (output, 1), update_pc (output, 32), update_taken (output, 1) and update_target (output, 32): training feedback to the predictor.
REQ-012 SHALL have ports branch_count (output, 32), mispredict_count (output, 32) and res_err (output, 1).

Function
REQ-013 SHALL hold accepted predictions in an in-order FIFO; pred_ready = (count < DEPTH) && state==IDLE.
REQ-014 SHALL perform an enqueue only when pred_valid && pred_ready.
REQ-015 SHALL wrap the read and write pointers modulo DEPTH and track occupancy with a separate count of 0..DEPTH.
REQ-016 SHALL compute, on res_valid with count>0, the correct path as res_taken ? res_target : head.pc + (head.is_rv32c ? 2 : 4), using 32-bit wrap-around arithmetic.
REQ-017 SHALL flag a mispredict when head.taken != res_taken, or when both are taken and head.target != res_target.
REQ-018 SHALL pop the head on every valid resolve.
REQ-019 SHALL, on a correctly predicted resolve, allow an enqueue in the same cycle; count changes by (enq - deq).
REQ-020 SHALL, on a mispredict, discard all remaining entries and any same-cycle enqueue, leaving count = 0 next cycle.
REQ-021 SHALL, on a mispredict, enter state REDIRECT for exactly one cycle, with redirect=1 and redirect_pc = correct path, registered one cycle after the resolve.
REQ-022 SHALL, in REDIRECT, drive pred_ready=0, ignore res_valid, and return to IDLE unconditionally.
REQ-023 SHALL use a state machine of IDLE and REDIRECT only.
REQ-024 SHALL, for every valid resolve, pulse update_valid one cycle later with update_pc = head.pc, update_taken = res_taken and update_target = res_target.
REQ-025 SHALL increment branch_count on every valid resolve and mispredict_count on every mispredict; both saturate at 0xFFFF_FFFF.
REQ-026 SHALL, on res_valid with count==0, set sticky res_err=1, leave the queue and counters unchanged, and emit no update or redirect.

Reset
REQ-027 SHALL, while nRST=0 (including mid-operation), clear count, pointers, counters, res_err, redirect, redirect_pc, update_* to 0 and force state IDLE.
REQ-028 SHALL have pred_ready=1 in the first cycle after reset release.

Structure
REQ-029 SHALL declare the pred_entry_t struct (pc, taken, target, is_rv32c) and the bru_state_t enum in rv32i_types_pkg, using word_t for 32-bit fields.
REQ-030 SHALL implement the queue as sub-module pred_fifo, with a flush input, parameterised by DEPTH and entry type.

Verification
REQ-031 SHALL cover: enqueue pc=0x100, taken, target=0xF0, not rv32c; resolve taken with target 0xF0 -> no redirect, update_valid=1 next cycle, branch_count=1.
REQ-032 SHALL cover: enqueue pc=0x200, not taken, rv32c; resolve taken with target 0x180 -> redirect=1 with redirect_pc=0x180 for 1 cycle, mispredict_count=1.
REQ-033 SHALL cover: enqueue pc=0x300, not taken, not rv32c, plus 3 more entries (full); resolve not taken -> no redirect; then taken with target 0x340 mispredict -> redirect_pc=0x340, count=0, pred_ready=0 for one cycle.
REQ-034 SHALL cover: enqueue pc=0x400, taken, target=0x3F0, not rv32c; resolve not taken -> redirect_pc=0x404; same-cycle enqueue discarded.
REQ-035 SHALL cover: res_valid with empty queue -> res_err=1 sticky, counters 0; nRST pulse mid-operation with 2 entries -> all outputs 0, pred_ready=1.
